// File: rtl/sseg_disp_mux.sv
// sseg_disp_mux
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   A free-running refresh counter splits the scan period into four equal
//   digit slots. The first BLANK_CYCLES clocks of every slot keep all anodes
//   off so the previous digit's pattern cannot ghost onto the next digit.
//   All outputs are registered (one clock behind the counter value that
//   produced them).
//
// Parameters
//   N_BITS        refresh counter width; scan = 2^N_BITS clocks,
//                 slot = 2^(N_BITS-2) clocks (minimum 4)
//   BLANK_CYCLES  all-off clocks at the start of each slot
//                 (0 .. 2^(N_BITS-2)-1, 0 disables blanking)
//
// Ports
//   i_clk         system clock
//   i_reset       synchronous, active-high reset
//   i_in0..i_in3  active-low segment patterns, digit 0 (rightmost) .. 3
//   i_en          per-digit enable, bit k enables digit k
//   o_an_n        active-low anode drives, bit k = digit k
//   o_sseg_n      active-low segment bus (pattern passed through unchanged)
//   o_digit       index of the digit whose slot is being output
//   o_frame_tick  one-clock pulse once per full scan
module sseg_disp_mux #(
  parameter int unsigned N_BITS       = 18,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_in0,
  input  logic [7:0] i_in1,
  input  logic [7:0] i_in2,
  input  logic [7:0] i_in3,
  input  logic [3:0] i_en,
  output logic [3:0] o_an_n,
  output logic [7:0] o_sseg_n,
  output logic [1:0] o_digit,
  output logic       o_frame_tick
);

  localparam int unsigned POS_W = N_BITS - 2;

  logic [N_BITS-1:0] r_cnt;
  logic [1:0]        sel;
  logic [POS_W-1:0]  pos;
  logic              blank;
  logic [7:0]        sel_pat;
  logic              sel_en;
  logic [3:0]        an_next;
  logic [7:0]        sseg_next;

  // Top two counter bits pick the digit, the rest is the position in the slot.
  assign sel = r_cnt[N_BITS-1:N_BITS-2];
  assign pos = r_cnt[POS_W-1:0];

  // With no blanking the comparison would be constant-false; tie it off
  // explicitly instead of comparing against zero.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank = 1'b0;
    end else begin : g_blank
      localparam logic [POS_W-1:0] BLANK_LIM = POS_W'(BLANK_CYCLES);
      assign blank = (pos < BLANK_LIM);
    end
  endgenerate

  always_comb begin
    sel_pat = i_in0;
    case (sel)
      2'd0: sel_pat = i_in0;
      2'd1: sel_pat = i_in1;
      2'd2: sel_pat = i_in2;
      2'd3: sel_pat = i_in3;
    endcase
  end

  assign sel_en = i_en[sel];

  // Disabled digits still occupy their slot, just dark.
  always_comb begin
    an_next   = '1;
    sseg_next = '1;
    if (!blank && sel_en) begin
      an_next   = ~(4'b0001 << sel);
      sseg_next = sel_pat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt        <= '0;
      o_an_n       <= '1;
      o_sseg_n     <= '1;
      o_digit      <= '0;
      o_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      o_an_n       <= an_next;
      o_sseg_n     <= sseg_next;
      o_digit      <= sel;
      o_frame_tick <= (r_cnt == '1);
    end
  end

endmodule

// File: doc/sseg_disp_mux.md
Name: sseg_disp_mux

Overview:
- Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Sits directly downstream of four hex-to-seven-segment decoders and takes their active-low segment patterns (seven segments plus decimal point).
- Scans one digit at a time and drives the shared segment bus and per-digit active-low anodes.
- Inserts a programmable blanking window at every digit change to suppress ghosting.

Parameters:
- N_BITS, 18: refresh counter width. Full scan period is 2^N_BITS clocks; each digit slot is 2^(N_BITS-2) clocks. Minimum 4.
- BLANK_CYCLES, 64: clocks at the start of each slot with all anodes off. Legal range is 0 to 2^(N_BITS-2)-1.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_in0  in  8  active-low segment pattern for digit 0 (rightmost)
- i_in1  in  8  active-low segment pattern for digit 1
- i_in2  in  8  active-low segment pattern for digit 2
- i_in3  in  8  active-low segment pattern for digit 3 (leftmost)
- i_en  in  4  per-digit enable; bit k enables digit k
- o_an_n  out  4  active-low anode drives; bit k = digit k
- o_sseg_n  out  8  active-low segment bus; pattern passed through bit-for-bit
- o_digit  out  2  index of the digit whose slot is being output
- o_frame_tick  out  1  one-clock pulse once per full scan

Behaviour:
- Clock and reset: single clock domain (i_clk). Reset is synchronous and active-high (i_reset), sampled on the rising edge of i_clk.
- Reset values: r_cnt=0, o_an_n=4'b1111, o_sseg_n=8'hFF, o_digit=0, o_frame_tick=0.
- Reset asserted mid-scan returns every output to its reset value at the next edge, regardless of the current slot.
- Counter: r_cnt (N_BITS wide) increments by 1 every clock and wraps from 2^N_BITS-1 to 0. There is no stall or enable.
- Slot decode, using current r_cnt:
  - sel = r_cnt[N_BITS-1:N_BITS-2]
  - pos = r_cnt[N_BITS-3:0]
  - blank = (pos < BLANK_CYCLES)
- Output registers, all updated on the same edge as r_cnt from the pre-increment r_cnt and the inputs sampled at that edge (one-clock latency):
  - o_digit <= sel.
  - If blank or i_en[sel]==0: o_an_n <= 4'b1111 and o_sseg_n <= 8'hFF.
  - Otherwise: o_an_n <= ~(4'b0001 << sel) and o_sseg_n <= i_in[sel].
  - o_frame_tick <= (r_cnt == 2^N_BITS-1). It is high for exactly one clock, the clock after the wrap edge.
- BLANK_CYCLES=0 means no blanking: every clock of an enabled slot drives its anode.
- At most one o_an_n bit is ever low. Anodes never overlap across a slot boundary because of the registered one-hot decode.
- Input changes during an active slot appear on o_sseg_n one clock later; they are not latched per slot.
- i_en may change at any time and takes effect one clock later.
- Digit order is 0,1,2,3,0,… with no skipping; disabled digits still consume their slot dark.

Test Plan (N_BITS=6, BLANK_CYCLES=2, so slot=16 clocks and scan=64 clocks):
- Reset held 3 clocks, then released with i_en=4'hF, i_in0..3=8'h03,8'h3F,8'h25,8'h0D -> first 2 output clocks o_an_n=4'hF, o_sseg_n=8'hFF; the next 14 clocks o_an_n=4'b1110, o_sseg_n=8'h03; then 2 blank clocks, then o_an_n=4'b1101, o_sseg_n=8'h3F; the pattern continues for digits 2 and 3.
- Free run for 128 clocks after reset -> o_frame_tick high exactly twice, 64 clocks apart. o_digit sequence is 0,1,2,3,0,… with 16 clocks each. o_an_n is never anything other than 4'hF or a one-hot-low value.
- i_en=4'b0101 -> during the slots of digits 1 and 3, o_an_n=4'hF and o_sseg_n=8'hFF for all 16 clocks; digits 0 and 2 display normally.
- Change i_in2 from 8'h25 to 8'h99 at clock 8 of digit 2's slot -> o_sseg_n shows 8'h99 from the next clock onward; o_an_n stays 4'b1011.
- Assert i_reset during digit 2's active window -> on the next edge o_an_n=4'hF, o_sseg_n=8'hFF, o_digit=0. After release, the scan restarts at digit 0 with its blank window.
- Re-run with BLANK_CYCLES=0 -> no all-off clocks at slot boundaries; o_an_n goes directly from 4'b1110 to 4'b1101 between consecutive clocks.
